dmem_responder: RTL and testbench

//   Responder end of the processor's data-memory port: multi-cycle word memory

---
 rtl/dmem_if.sv | 40 ++++
 rtl/dmem_responder.sv | 162 ++++++++++++++++
 tb/tb_dmem_responder.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_if.sv
// dmem_if: data-memory port between a processor core (initiator, master
// modport) and a memory responder (slave modport).
//
// Handshake: a request is taken on a rising edge where req=1 and ready=1.
// The initiator may drop req or change addr/we/wdata/be after that edge without
// affecting the accepted transaction. ready stays low until the transaction
// completes. Completion is a one-cycle ack pulse, and rdata/err are valid only
// in that cycle.
//
// Signals:
//   req    initiator -> responder  request, looked at only while ready=1
//   we     initiator -> responder  1 = write, 0 = read
//   addr   initiator -> responder  byte address
//   wdata  initiator -> responder  write data, lane i = bits 8i+7:8i
//   be     initiator -> responder  write byte enables
//   ready  responder -> initiator  idle, able to accept this cycle
//   ack    responder -> initiator  one-cycle completion pulse
//   rdata  responder -> initiator  read data (0 for writes and errors)
//   err    responder -> initiator  misaligned or out-of-range access
interface dmem_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        ready;
  logic        ack;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, we, addr, wdata, be,
    input  ready, ack, rdata, err
  );

  modport slave (
    input  req, we, addr, wdata, be,
    output ready, ack, rdata, err
  );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: responder end of the processor's data-memory port.
// This is a multi-cycle word memory with a programmable number of wait states
// between acceptance and ack. Writes use byte enables. Misaligned and
// out-of-range accesses are reported through err.
//
// Parameters:
//   DEPTH_WORDS  storage size in 32-bit words (power of two)
//   WAIT_CYCLES  wait states between the acceptance edge and the ack cycle
//
// Ports:
//   clk        clock, all state changes on posedge
//   reset      synchronous, active-high reset
//   bus        dmem_if slave modport (req/we/addr/wdata/be in,
//              ready/ack/rdata/err out)
//   dbg_state  current FSM state (0 = IDLE, 1 = WAIT, 2 = ACK)
//
// Storage is not cleared by reset, so its contents survive a reset.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  dmem_if.slave      bus,
  output logic [1:0] dbg_state
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Fields captured on the acceptance edge.
  logic        lat_we;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [3:0]  lat_be;

  logic [31:0] rdata_q;
  logic        err_q;

  logic [31:0] words [0:DEPTH_WORDS-1];

  logic accept;
  logic do_access;

  // Operands of the access performed on the edge entering ACK. With zero wait
  // states that edge is also the acceptance edge, so the fields come straight
  // from the bus. Otherwise they come from the latched copy, which keeps later
  // bus activity from leaking into the transaction.
  logic             acc_from_bus;
  logic             acc_we;
  logic [31:0]      acc_addr;
  logic [31:0]      acc_wdata;
  logic [3:0]       acc_be;
  logic             acc_bad;
  logic [IDX_W-1:0] acc_idx;

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    accept    = 1'b0;
    do_access = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.req) begin
          accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_d   = ST_ACK;
            do_access = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = '0;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == CNT_LAST) begin
          state_d   = ST_ACK;
          do_access = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    acc_from_bus = (state_q == ST_IDLE);
    acc_we       = acc_from_bus ? bus.we    : lat_we;
    acc_addr     = acc_from_bus ? bus.addr  : lat_addr;
    acc_wdata    = acc_from_bus ? bus.wdata : lat_wdata;
    acc_be       = acc_from_bus ? bus.be    : lat_be;
    // Out of range means any address bit above the word-index field is set.
    acc_bad      = (acc_addr[1:0] != 2'b00) || (|acc_addr[31:IDX_W+2]);
    acc_idx      = acc_addr[IDX_W+1:2];
  end

  // State register and response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      // err is only ever high during the ack cycle.
      err_q   <= do_access ? acc_bad : 1'b0;
      if (do_access) begin
        rdata_q <= (acc_bad || acc_we) ? 32'h0 : words[acc_idx];
      end
    end
  end

  // Request capture. These registers need no reset because they are only read
  // while a transaction is in flight.
  always_ff @(posedge clk) begin
    if (accept && !reset) begin
      lat_we    <= bus.we;
      lat_addr  <= bus.addr;
      lat_wdata <= bus.wdata;
      lat_be    <= bus.be;
    end
  end

  // Storage. A reset on the ACK-entry edge discards the pending write.
  always_ff @(posedge clk) begin
    if (!reset && do_access && acc_we && !acc_bad) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_be[i]) begin
          words[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
        end
      end
    end
  end

  // ready also follows reset directly, so it is low for every reset cycle.
  assign bus.ready = (state_q == ST_IDLE) && !reset;
  assign bus.ack   = (state_q == ST_ACK);
  assign bus.rdata = rdata_q;
  assign bus.err   = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder. It runs two instances: index 0 with zero wait
// states and index 1 with two wait states, both 1024 words deep.
//
// The reference model works at transaction level. A request seen while the
// responder is idle (and not in reset) is scheduled to complete
// WAIT_CYCLES+1 cycles later. The memory image is updated and the response is
// computed when that cycle arrives. A reset cancels anything outstanding.
// One negedge process compares both instances against the model every cycle.
module tb_dmem_responder;
  localparam int DEPTH = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_s   [2];
  logic        req_s   [2];
  logic        we_s    [2];
  logic [31:0] addr_s  [2];
  logic [31:0] wdata_s [2];
  logic [3:0]  be_s    [2];
  logic        ready_o [2];
  logic        ack_o   [2];
  logic        err_o   [2];
  logic [31:0] rdata_o [2];
  logic [1:0]  dbg0, dbg1;

  dmem_if bus0 ();
  dmem_if bus1 ();

  assign bus0.req   = req_s[0];
  assign bus0.we    = we_s[0];
  assign bus0.addr  = addr_s[0];
  assign bus0.wdata = wdata_s[0];
  assign bus0.be    = be_s[0];
  assign bus1.req   = req_s[1];
  assign bus1.we    = we_s[1];
  assign bus1.addr  = addr_s[1];
  assign bus1.wdata = wdata_s[1];
  assign bus1.be    = be_s[1];
  assign ready_o[0] = bus0.ready;
  assign ack_o[0]   = bus0.ack;
  assign rdata_o[0] = bus0.rdata;
  assign err_o[0]   = bus0.err;
  assign ready_o[1] = bus1.ready;
  assign ack_o[1]   = bus1.ack;
  assign rdata_o[1] = bus1.rdata;
  assign err_o[1]   = bus1.err;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(rst_s[0]), .bus(bus0), .dbg_state(dbg0)
  );
  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) dut1 (
    .clk(clk), .reset(rst_s[1]), .bus(bus1), .dbg_state(dbg1)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int k, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d actual=%h expected=%h t=%0t", nm, k, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] mdl_mem [2][DEPTH];
  bit          armed   [2];
  bit          pend    [2];
  longint      ack_cyc [2];
  bit          p_we    [2];
  logic [31:0] p_addr  [2];
  logic [31:0] p_wdata [2];
  logic [3:0]  p_be    [2];
  longint      cyc = 0;

  function automatic int wait_of(input int k);
    return (k == 0) ? 0 : 2;
  endfunction

  // Transaction bookkeeping at the end of each cycle (inputs are stable here).
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst_s[k]) begin
        armed[k] = 1'b1;
        pend[k]  = 1'b0;
      end else if (armed[k]) begin
        if (pend[k]) begin
          if (cyc == ack_cyc[k]) pend[k] = 1'b0;
        end else if (req_s[k]) begin
          pend[k]    = 1'b1;
          ack_cyc[k] = cyc + wait_of(k) + 1;
          p_we[k]    = we_s[k];
          p_addr[k]  = addr_s[k];
          p_wdata[k] = wdata_s[k];
          p_be[k]    = be_s[k];
        end
      end
    end
    cyc++;
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    logic        e_ready, e_ack, e_err;
    logic [31:0] e_rd;
    logic [9:0]  idx;
    for (int k = 0; k < 2; k++) begin
      if (armed[k]) begin
        e_ready = !rst_s[k] && !pend[k];
        e_ack   = pend[k] && (cyc == ack_cyc[k]);
        chk("ready", k, 32'(ready_o[k]), 32'(e_ready));
        chk("ack", k, 32'(ack_o[k]), 32'(e_ack));
        if (e_ack) begin
          e_err = (p_addr[k][1:0] != 2'b00) || (p_addr[k] >= 32'(4 * DEPTH));
          idx   = p_addr[k][11:2];
          e_rd  = (e_err || p_we[k]) ? 32'h0 : mdl_mem[k][idx];
          if (!e_err && p_we[k]) begin
            for (int b = 0; b < 4; b++) begin
              if (p_be[k][b]) mdl_mem[k][idx][8*b +: 8] = p_wdata[k][8*b +: 8];
            end
          end
          chk("err", k, 32'(err_o[k]), 32'(e_err));
          chk("rdata", k, rdata_o[k], e_rd);
        end else begin
          chk("err_idle", k, 32'(err_o[k]), 32'h0);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called mid-cycle. Presents a request, waits for acceptance, scrambles the
  // inputs, then waits for the ack. Returns at the negedge of the ack cycle.
  task automatic txn(input int k, input bit w, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] b,
                     output logic [31:0] rd, output logic e, output int lat);
    int n;
    rd = 32'h0;
    e = 1'b0;
    lat = 0;
    req_s[k] = 1'b1; we_s[k] = w; addr_s[k] = a; wdata_s[k] = d; be_s[k] = b;
    n = 0;
    while (!ready_o[k]) begin
      @(negedge clk);
      n++;
      if (n > 50) begin
        chk("ready_timeout", k, 32'h0, 32'h1);
        req_s[k] = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    req_s[k] = 1'b0; we_s[k] = $urandom_range(0, 1);
    addr_s[k] = $urandom; wdata_s[k] = $urandom; be_s[k] = 4'($urandom);
    while (1) begin
      @(negedge clk);
      lat++;
      if (ack_o[k]) begin
        rd = rdata_o[k];
        e = err_o[k];
        break;
      end
      if (lat > 50) begin
        chk("ack_timeout", k, 32'h0, 32'h1);
        break;
      end
    end
  endtask

  function automatic logic [31:0] rnd_addr();
    int          s = $urandom_range(0, 9);
    logic [31:0] a = {20'h0, 10'($urandom_range(0, DEPTH - 1)), 2'b00};
    if (s == 0) a[1:0] = 2'($urandom_range(1, 3));
    else if (s == 1) a = $urandom | 32'h0000_1000;
    else if (s == 2) a = 32'h0000_0FFC;
    else if (s == 3) a = 32'h0000_1000;
    return a;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] rd;
    logic        e;
    int          lat;
    int          acks [2];
    logic [31:0] pre;
    for (int k = 0; k < 2; k++) begin
      rst_s[k] = 1'b1; req_s[k] = 1'b0; we_s[k] = 1'b0;
      addr_s[k] = '0; wdata_s[k] = '0; be_s[k] = '0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_ready", k, 32'(ready_o[k]), 32'h0);
      chk("rst_ack", k, 32'(ack_o[k]), 32'h0);
      chk("rst_err", k, 32'(err_o[k]), 32'h0);
      chk("rst_rdata", k, rdata_o[k], 32'h0);
    end
    @(posedge clk); #1;
    rst_s[0] = 1'b0; rst_s[1] = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 0, 32'(ready_o[0]), 32'h1);
    chk("ready_after_rst", 1, 32'(ready_o[1]), 32'h1);

    // Fill both memories with random words through the port.
    fork
      begin
        logic [31:0] r0; logic e0; int l0;
        for (int i = 0; i < DEPTH; i++) txn(0, 1'b1, 32'(4 * i), $urandom, 4'hF, r0, e0, l0);
      end
      begin
        logic [31:0] r1; logic e1; int l1;
        for (int i = 0; i < DEPTH; i++) txn(1, 1'b1, 32'(4 * i), $urandom, 4'hF, r1, e1, l1);
      end
    join
    @(negedge clk);

    // Full-word write then read, with latency and ready recovery.
    txn(1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, e, lat);
    chk("t1_wr_lat", 1, 32'(lat), 32'd3);
    chk("t1_wr_err", 1, 32'(e), 32'h0);
    @(negedge clk);
    chk("t1_ready_back", 1, 32'(ready_o[1]), 32'h1);
    txn(1, 1'b0, 32'h10, 32'h0, 4'h0, rd, e, lat);
    chk("t1_rd_lat", 1, 32'(lat), 32'd3);
    chk("t1_rd_data", 1, rd, 32'hDEADBEEF);
    chk("t1_rd_err", 1, 32'(e), 32'h0);

    // Single-lane write.
    txn(1, 1'b1, 32'h10, 32'h0000AA00, 4'b0010, rd, e, lat);
    txn(1, 1'b0, 32'h10, 32'h0, 4'h0, rd, e, lat);
    chk("t2_rd_data", 1, rd, 32'hDEADAAEF);

    // Misaligned accesses.
    txn(1, 1'b0, 32'h13, 32'h0, 4'h0, rd, e, lat);
    chk("t3_mis_err", 1, 32'(e), 32'h1);
    chk("t3_mis_rdata", 1, rd, 32'h0);
    txn(1, 1'b1, 32'h12, 32'h12345678, 4'hF, rd, e, lat);
    chk("t3_mis_wr_err", 1, 32'(e), 32'h1);
    txn(1, 1'b0, 32'h10, 32'h0, 4'h0, rd, e, lat);
    chk("t3_rd_data", 1, rd, 32'hDEADAAEF);

    // Range boundary.
    txn(1, 1'b1, 32'h1000, 32'h55555555, 4'hF, rd, e, lat);
    chk("t4_oor_err", 1, 32'(e), 32'h1);
    pre = mdl_mem[1][DEPTH-1];
    txn(1, 1'b0, 32'hFFC, 32'h0, 4'h0, rd, e, lat);
    chk("t4_last_err", 1, 32'(e), 32'h0);
    chk("t4_last_data", 1, rd, pre);

    // Zero byte enables: no change, no error.
    txn(1, 1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, rd, e, lat);
    chk("be0_err", 1, 32'(e), 32'h0);
    txn(1, 1'b0, 32'h10, 32'h0, 4'h0, rd, e, lat);
    chk("be0_data", 1, rd, 32'hDEADAAEF);

    // Reset during WAIT discards the write.
    txn(1, 1'b1, 32'h20, 32'hCAFEF00D, 4'hF, rd, e, lat);
    req_s[1] = 1'b1; we_s[1] = 1'b1; addr_s[1] = 32'h20;
    wdata_s[1] = 32'h11111111; be_s[1] = 4'hF;
    while (!ready_o[1]) @(negedge clk);
    @(posedge clk); #1;
    rst_s[1] = 1'b1; req_s[1] = 1'b0;
    @(posedge clk); #1;
    rst_s[1] = 1'b0;
    @(negedge clk);
    chk("t5_ready_first", 1, 32'(ready_o[1]), 32'h1);
    acks[1] = 0;
    for (int i = 0; i < 6; i++) begin
      if (ack_o[1]) acks[1]++;
      @(negedge clk);
    end
    chk("t5_no_ack", 1, 32'(acks[1]), 32'h0);
    txn(1, 1'b0, 32'h20, 32'h0, 4'h0, rd, e, lat);
    chk("t5_rd_data", 1, rd, 32'hCAFEF00D);

    // Request held high: throughput for zero and two wait states.
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      req_s[k] = 1'b1; we_s[k] = 1'b0; addr_s[k] = 32'h40; acks[k] = 0;
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) if (ack_o[k]) acks[k]++;
    end
    req_s[0] = 1'b0; req_s[1] = 1'b0;
    chk("t6_acks_w0", 0, 32'(acks[0]), 32'd10);
    chk("t6_acks_w2", 1, 32'(acks[1]), 32'd5);
    repeat (6) @(negedge clk);

    // Random traffic with occasional resets; the model checks every cycle.
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++) begin
        rst_s[k]   = ($urandom_range(0, 63) == 0);
        req_s[k]   = ($urandom_range(0, 2) != 0);
        we_s[k]    = $urandom_range(0, 1);
        addr_s[k]  = rnd_addr();
        wdata_s[k] = $urandom;
        be_s[k]    = 4'($urandom_range(0, 15));
      end
    end
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      rst_s[k] = 1'b0; req_s[k] = 1'b0;
    end
    repeat (10) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    n_chk++;
    n_fail++;
    $display("FAIL watchdog actual=running expected=finished t=%0t", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
